// File: rtl/layer_5_if.sv
// Streaming/result interface of the layer_5 classifier stage.
//   din_vld, din  : one beat of LANES activations from the ReLU layer
//   in_rdy        : classifier accepts beats (IDLE/LOAD only)
//   tx_done       : downstream consumed the result; also aborts a frame
//   rdy           : result valid (level)
//   digit, score  : arg-max class index and its signed score
// master = upstream/downstream side, slave = classifier side.
interface layer_5_if #(
   parameter int LANES = 16,
   parameter int DIN_W = 18,
   parameter int ACC_W = 36
);
   logic                        din_vld;
   logic [LANES-1:0][DIN_W-1:0] din;
   logic                        in_rdy;
   logic                        tx_done;
   logic                        rdy;
   logic [3:0]                  digit;
   logic [ACC_W-1:0]            score;

   modport master (
      output din_vld, din, tx_done,
      input  in_rdy, rdy, digit, score
   );

   modport slave (
      input  din_vld, din, tx_done,
      output in_rdy, rdy, digit, score
   );
endinterface

// File: rtl/layer_5.sv
// layer_5: final fully-connected classifier. Captures 64 activations in
// BEATS beats of LANES lanes, runs a 64-term signed MAC plus bias for each
// of N_OUT classes, picks the arg-max and holds it until tx_done.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : layer_5_if slave modport (din_vld/din/in_rdy/tx_done/rdy/digit/score)
// Weight and bias ROM contents arrive through W_ROM / B_ROM, one row per
// class (the l5_W<n> / l5_B<n> tables). LANES must be a power of two.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for beat 0
// LOAD  | collecting beats 1..BEATS-1
// PRIME | ROM address 0 presented, accumulators loaded with bias
// MAC   | one input index per cycle into all class accumulators
// ARG   | serial arg-max over the class accumulators
// DONE  | result held on rdy/digit/score until tx_done
module layer_5 #(
   parameter int LANES = 16,
   parameter int BEATS = 4,
   parameter int N_OUT = 10,
   parameter int DIN_W = 18,
   parameter int W_W   = 9,
   parameter int ACC_W = 36,
   parameter logic [N_OUT-1:0][LANES*BEATS-1:0][W_W-1:0] W_ROM = '0,
   parameter logic [N_OUT-1:0][W_W-1:0]                  B_ROM = '0
) (
   input logic      clk,
   input logic      rst,
   layer_5_if.slave bus
);
   localparam int N_IN = LANES * BEATS;
   localparam int IW   = $clog2(N_IN);
   localparam int LW   = $clog2(LANES);
   localparam int BW   = $clog2(BEATS);
   localparam int KW   = $clog2(N_OUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PRIME, S_MAC, S_ARG, S_DONE
   } state_t;

   state_t                      state;
   logic [BW-1:0]               beat;
   logic [IW-1:0]               idx;
   logic [KW-1:0]               k;
   logic                        in_rdy_q;
   logic                        rdy_q;
   logic [3:0]                  digit_q;
   logic [ACC_W-1:0]            score_q;
   logic signed [ACC_W-1:0]     acc [N_OUT];
   logic signed [ACC_W-1:0]     best;
   logic [KW-1:0]               bidx;
   logic [LANES-1:0][DIN_W-1:0] in_buf [BEATS];
   logic [W_W-1:0]              w_q [N_OUT];

   logic [IW-1:0]               rom_addr;
   logic [DIN_W-1:0]            x_cur;
   logic signed [ACC_W-1:0]     x_ext;
   logic                        take;
   logic signed [ACC_W-1:0]     best_nxt;
   logic [KW-1:0]               bidx_nxt;
   logic                        beat_wr;

   // ROM address runs one ahead of idx so w_q lines up with in_buf[idx].
   assign rom_addr = (state == S_MAC) ? idx + IW'(1) : '0;

   assign x_cur = in_buf[idx[IW-1:LW]][idx[LW-1:0]];
   assign x_ext = $signed({{(ACC_W-DIN_W){x_cur[DIN_W-1]}}, x_cur});

   // Strict greater-than keeps the lower class index on ties.
   always_comb begin
      take     = (k == '0) || (acc[k] > best);
      best_nxt = take ? acc[k] : best;
      bidx_nxt = take ? k : bidx;
   end

   assign beat_wr = !rst && !bus.tx_done && bus.din_vld &&
                    ((state == S_IDLE) || (state == S_LOAD));

   always_ff @(posedge clk) begin
      if (beat_wr) begin
         in_buf[beat] <= bus.din;
      end
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < N_OUT; n++) begin
         w_q[n] <= W_ROM[n][rom_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         beat     <= '0;
         idx      <= '0;
         k        <= '0;
         in_rdy_q <= 1'b1;
         rdy_q    <= 1'b0;
         digit_q  <= '0;
         score_q  <= '0;
         best     <= '0;
         bidx     <= '0;
         for (int n = 0; n < N_OUT; n++) begin
            acc[n] <= '0;
         end
      end else if (bus.tx_done) begin
         state    <= S_IDLE;
         beat     <= '0;
         idx      <= '0;
         k        <= '0;
         in_rdy_q <= 1'b1;
         rdy_q    <= 1'b0;
         digit_q  <= '0;
         score_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.din_vld) begin
                  beat  <= BW'(1);
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (bus.din_vld) begin
                  if (beat == BW'(BEATS-1)) begin
                     beat     <= '0;
                     in_rdy_q <= 1'b0;
                     state    <= S_PRIME;
                  end else begin
                     beat <= beat + BW'(1);
                  end
               end
            end
            S_PRIME: begin
               for (int n = 0; n < N_OUT; n++) begin
                  acc[n] <= $signed({{(ACC_W-W_W){B_ROM[n][W_W-1]}}, B_ROM[n]});
               end
               idx   <= '0;
               state <= S_MAC;
            end
            S_MAC: begin
               // Product truncated to ACC_W: accumulation wraps, no saturation.
               for (int n = 0; n < N_OUT; n++) begin
                  acc[n] <= acc[n] +
                     x_ext * $signed({{(ACC_W-W_W){w_q[n][W_W-1]}}, w_q[n]});
               end
               if (idx == IW'(N_IN-1)) begin
                  k     <= '0;
                  state <= S_ARG;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            S_ARG: begin
               best <= best_nxt;
               bidx <= bidx_nxt;
               if (k == KW'(N_OUT-1)) begin
                  rdy_q   <= 1'b1;
                  digit_q <= 4'(bidx_nxt);
                  score_q <= best_nxt;
                  state   <= S_DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_DONE: begin
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_rdy = in_rdy_q;
   assign bus.rdy    = rdy_q;
   assign bus.digit  = digit_q;
   assign bus.score  = score_q;
endmodule
